// File: rtl/multi_dataflow_job_offloader_pkg.sv
// rtl/multi_dataflow_job_offloader_pkg.sv - shared types and register map for the job offloader
package multi_dataflow_offload_package;

    typedef enum logic [2:0] {
        IDLE,
        ACQ_REQ,
        ACQ_WAIT,
        BACKOFF,
        WR,
        TRIG,
        WAIT_EVT
    } offload_state_t;

    localparam logic [31:0] OFFL_TRIGGER = 32'h00;
    localparam logic [31:0] OFFL_ACQUIRE = 32'h04;
    localparam logic [31:0] OFFL_JOBREGS = 32'h40;

    localparam int ACQ_LOCKED_BIT = 31;

endpackage

// File: rtl/multi_dataflow_job_offloader.sv
// rtl/multi_dataflow_job_offloader.sv - periph-bus initiator that acquires, loads and triggers accelerator jobs
module multi_dataflow_job_offloader
    import multi_dataflow_offload_package::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          N_IO_REGS    = 25,
    parameter int          ID_WIDTH     = 8,
    parameter int          REQ_ID       = 0,
    parameter int          RETRY_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                jobw_valid_i,
    output logic                jobw_ready_o,
    input  logic [31:0]         jobw_data_i,
    input  logic                jobw_last_i,
    input  logic                evt_i,
    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          job_id_o
);

    localparam int KW = $clog2(N_IO_REGS + 1);
    localparam int BW = $clog2(RETRY_CYCLES + 1);
    localparam logic [KW-1:0]       K_MAX    = KW'(N_IO_REGS);
    localparam logic [BW-1:0]       B_LAST   = BW'(RETRY_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0] REQ_ID_W = ID_WIDTH'(REQ_ID);

    offload_state_t state_q;
    logic [KW-1:0]  k_q;
    logic [BW-1:0]  boff_q;
    logic           done_q;
    logic           err_q;
    logic [7:0]     job_id_q;

    logic k_room;
    logic word_hs;
    logic unused_rdata;

    assign k_room       = (k_q < K_MAX);
    assign word_hs      = jobw_valid_i && jobw_ready_o;
    assign unused_rdata = ^periph_r_data_i[30:8];

    // Bus and stream outputs decoded from state; WR is a zero-buffer pass-through of the job stream
    always_comb begin
        periph_req_o  = 1'b0;
        periph_wen_o  = 1'b0;
        periph_add_o  = 32'h0;
        periph_data_o = 32'h0;
        jobw_ready_o  = 1'b0;
        case (state_q)
            ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_wen_o = 1'b1;
                periph_add_o = BASE_ADDR + OFFL_ACQUIRE;
            end
            WR: begin
                if (k_room) begin
                    periph_req_o  = jobw_valid_i;
                    periph_add_o  = BASE_ADDR + OFFL_JOBREGS + 32'({k_q, 2'b00});
                    periph_data_o = jobw_data_i;
                    jobw_ready_o  = periph_gnt_i;
                end else begin
                    jobw_ready_o  = 1'b1;
                end
            end
            TRIG: begin
                periph_req_o = 1'b1;
                periph_add_o = BASE_ADDR + OFFL_TRIGGER;
            end
            default: ;
        endcase
    end

    assign periph_be_o = 4'hF;
    assign periph_id_o = REQ_ID_W;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign job_id_o    = job_id_q;

    // Job sequencing: acquire a context (with backoff while locked), stream registers, trigger, await event
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            boff_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            job_id_q <= 8'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (jobw_valid_i) begin
                        state_q <= ACQ_REQ;
                        k_q     <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ACQ_REQ: begin
                    if (periph_gnt_i) state_q <= ACQ_WAIT;
                end
                ACQ_WAIT: begin
                    if (periph_r_valid_i && (periph_r_id_i == REQ_ID_W)) begin
                        if (periph_r_data_i[ACQ_LOCKED_BIT]) begin
                            state_q <= BACKOFF;
                            boff_q  <= '0;
                        end else begin
                            job_id_q <= periph_r_data_i[7:0];
                            state_q  <= WR;
                        end
                    end
                end
                BACKOFF: begin
                    if (boff_q == B_LAST) state_q <= ACQ_REQ;
                    else                  boff_q  <= boff_q + 1'b1;
                end
                WR: begin
                    if (word_hs) begin
                        if (k_room) k_q   <= k_q + 1'b1;
                        else        err_q <= 1'b1;
                        if (jobw_last_i) state_q <= TRIG;
                    end
                end
                TRIG: begin
                    if (periph_gnt_i) state_q <= WAIT_EVT;
                end
                WAIT_EVT: begin
                    if (evt_i) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_dataflow_job_offloader.sv
// tb/tb_multi_dataflow_job_offloader.sv - directed self-checking bench for the job offloader
module tb_multi_dataflow_job_offloader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        jobw_valid_i, jobw_ready_o, jobw_last_i;
    logic [31:0] jobw_data_i;
    logic        evt_i;
    logic        periph_req_o, periph_gnt_i, periph_wen_o;
    logic [31:0] periph_add_o, periph_data_o;
    logic [3:0]  periph_be_o;
    logic [7:0]  periph_id_o;
    logic        periph_r_valid_i;
    logic [31:0] periph_r_data_i;
    logic [7:0]  periph_r_id_i;
    logic        busy_o, done_o, err_o;
    logic [7:0]  job_id_o;

    multi_dataflow_job_offloader dut (
        .clk_i(clk), .rst_i(rst_i),
        .jobw_valid_i(jobw_valid_i), .jobw_ready_o(jobw_ready_o),
        .jobw_data_i(jobw_data_i), .jobw_last_i(jobw_last_i),
        .evt_i(evt_i),
        .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
        .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
        .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o),
        .periph_r_valid_i(periph_r_valid_i), .periph_r_data_i(periph_r_data_i),
        .periph_r_id_i(periph_r_id_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .job_id_o(job_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] add;
        logic [31:0] data;
        logic        wen;
        int          cyc;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] acq_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          gnt_rand = 0;
    bit          rd_pend = 0;
    bit          evt_pend = 0;
    int          bad_id_cnt = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    bit          hold = 0;
    logic [31:0] hold_add, hold_data;
    logic        hold_wen;

    always @(posedge clk) cyc <= cyc + 1;

    // Accelerator-side periph slave model and bus monitor
    always @(negedge clk) begin
        evt_i = evt_pend;
        evt_pend = 0;
        periph_r_valid_i = 1'b0;
        periph_r_id_i    = 8'h0;
        periph_r_data_i  = 32'h0;
        if (rd_pend) begin
            periph_r_valid_i = 1'b1;
            if (bad_id_cnt > 0) begin
                periph_r_id_i   = 8'h3;
                periph_r_data_i = 32'h0000_0042;
                bad_id_cnt--;
            end else begin
                periph_r_data_i = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h5;
                rd_pend = 0;
            end
        end
        periph_gnt_i = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        #2;
        if (periph_req_o && periph_gnt_i) begin
            log_q.push_back('{add: periph_add_o, data: periph_data_o, wen: periph_wen_o, cyc: cyc});
            if (periph_wen_o) rd_pend = 1;
            if (!periph_wen_o && periph_add_o == BASE) evt_pend = 1;
        end
        if (hold && periph_req_o &&
            (periph_add_o != hold_add || periph_data_o != hold_data || periph_wen_o != hold_wen))
            stab_err++;
        hold      = periph_req_o && !periph_gnt_i;
        hold_add  = periph_add_o;
        hold_data = periph_data_o;
        hold_wen  = periph_wen_o;
        if (done_o) done_cnt++;
    end

    task automatic send_job(input int n, input logic [31:0] base, input bit stall,
                            output int hs_cnt, output int start_cyc);
        int w;
        bit hs;
        hs_cnt = 0;
        start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            hs = 0;
            while (!hs && w < 400) begin
                @(negedge clk);
                jobw_valid_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                jobw_data_i  = base + i;
                jobw_last_i  = (i == n - 1);
                if (i == 0 && w == 0) start_cyc = cyc;
                #1;
                hs = jobw_valid_i && jobw_ready_o;
                w++;
            end
            if (!hs) begin
                checks++; errors++;
                $display("FAIL word_accept_timeout: word %0d not accepted, expected handshake", i);
                break;
            end
            hs_cnt++;
        end
        @(negedge clk);
        jobw_valid_i = 1'b0;
        jobw_last_i  = 1'b0;
    endtask

    task automatic wait_done(output int end_cyc);
        bit seen;
        seen = 0;
        end_cyc = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_o) begin
                seen = 1;
                end_cyc = cyc;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done_o=0, expected pulse");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (periph_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", periph_req_o); end
        checks++; if (jobw_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", jobw_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
        checks++; if (job_id_o !== 8'h0) begin errors++; $display("FAIL rst_job_id: got %h expected 00", job_id_o); end
        checks++; if (periph_add_o !== 32'h0 || periph_data_o !== 32'h0 || periph_wen_o !== 1'b0) begin
            errors++; $display("FAIL rst_bus: got add=%h data=%h wen=%b expected 0/0/0", periph_add_o, periph_data_o, periph_wen_o);
        end
        checks++; if (periph_be_o !== 4'hF) begin errors++; $display("FAIL rst_be: got %h expected f", periph_be_o); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int hs, t0, t1;
        logic [31:0] exp_add [5] = '{32'h04, 32'h40, 32'h44, 32'h48, 32'h00};
        logic [31:0] exp_dat [5] = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
        logic        exp_wen [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h5}; done_cnt = 0;
        send_job(3, 32'hA, 0, hs, t0);
        wait_done(t1);
        checks++; if (log_q.size() != 5) begin errors++; $display("FAIL single_txn_count: got %0d expected 5", log_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_q[i].add !== BASE + exp_add[i] || log_q[i].wen !== exp_wen[i] ||
                (!exp_wen[i] && log_q[i].data !== exp_dat[i])) begin
                errors++;
                $display("FAIL single_txn%0d: got add=%h data=%h wen=%b expected add=%h data=%h wen=%b",
                         i, log_q[i].add, log_q[i].data, log_q[i].wen, BASE + exp_add[i], exp_dat[i], exp_wen[i]);
            end
        end
        checks++; if (job_id_o !== 8'h05) begin errors++; $display("FAIL single_job_id: got %h expected 05", job_id_o); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_o); end
        checks++; if (t1 - t0 != 8) begin errors++; $display("FAIL single_latency: got %0d expected 8", t1 - t0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy_o); end
    endtask

    task automatic test_min_latency();
        int hs, t0, t1;
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h9};
        send_job(1, 32'h77, 0, hs, t0);
        wait_done(t1);
        checks++; if (t1 - t0 != 6) begin errors++; $display("FAIL min_latency: got %0d expected 6", t1 - t0); end
    endtask

    task automatic test_retry();
        int hs, t0, t1, nrd;
        int rd_cyc[$];
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h8000_0000, 32'h8000_0000, 32'h1};
        send_job(2, 32'h20, 0, hs, t0);
        wait_done(t1);
        foreach (log_q[i]) if (log_q[i].wen) rd_cyc.push_back(log_q[i].cyc);
        nrd = rd_cyc.size();
        checks++; if (nrd != 3) begin errors++; $display("FAIL retry_reads: got %0d expected 3", nrd); end
        else for (int i = 1; i < 3; i++) begin
            checks++;
            if (rd_cyc[i] - rd_cyc[i-1] < 16) begin
                errors++; $display("FAIL retry_gap%0d: got %0d expected >=16", i, rd_cyc[i] - rd_cyc[i-1]);
            end
        end
        checks++; if (job_id_o !== 8'h01) begin errors++; $display("FAIL retry_job_id: got %h expected 01", job_id_o); end
    endtask

    task automatic test_bad_id();
        int hs, t0, t1, nrd;
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h7}; bad_id_cnt = 2;
        send_job(1, 32'h30, 0, hs, t0);
        wait_done(t1);
        nrd = 0;
        foreach (log_q[i]) if (log_q[i].wen) nrd++;
        checks++; if (job_id_o !== 8'h07) begin errors++; $display("FAIL badid_job_id: got %h expected 07", job_id_o); end
        checks++; if (nrd != 1) begin errors++; $display("FAIL badid_reads: got %0d expected 1", nrd); end
    endtask

    task automatic test_stall();
        int hs, t0, t1, nwr;
        txn_t wr[$];
        gnt_rand = 1; log_q.delete(); acq_q = '{32'h3}; stab_err = 0;
        send_job(25, 32'h100, 1, hs, t0);
        wait_done(t1);
        gnt_rand = 0;
        foreach (log_q[i]) if (!log_q[i].wen && log_q[i].add >= BASE + 32'h40) wr.push_back(log_q[i]);
        nwr = wr.size();
        checks++; if (nwr != 25) begin errors++; $display("FAIL stall_writes: got %0d expected 25", nwr); end
        else for (int i = 0; i < 25; i++) begin
            checks++;
            if (wr[i].add !== BASE + 32'h40 + 4 * i || wr[i].data !== 32'h100 + i) begin
                errors++; $display("FAIL stall_word%0d: got add=%h data=%h expected add=%h data=%h",
                                   i, wr[i].add, wr[i].data, BASE + 32'h40 + 4 * i, 32'h100 + i);
            end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stability: got %0d changes expected 0", stab_err); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL stall_err: got %b expected 0", err_o); end
    endtask

    task automatic test_overflow();
        int hs, t0, t1, nwr, ntrig;
        logic [31:0] last_add;
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h2};
        send_job(27, 32'h200, 0, hs, t0);
        wait_done(t1);
        nwr = 0; ntrig = 0; last_add = 32'h0;
        foreach (log_q[i]) begin
            if (!log_q[i].wen && log_q[i].add >= BASE + 32'h40) begin nwr++; last_add = log_q[i].add; end
            if (!log_q[i].wen && log_q[i].add == BASE) ntrig++;
        end
        checks++; if (nwr != 25) begin errors++; $display("FAIL ovf_writes: got %0d expected 25", nwr); end
        checks++; if (hs - nwr != 2) begin errors++; $display("FAIL ovf_discarded: got %0d expected 2", hs - nwr); end
        checks++; if (last_add !== BASE + 32'hA0) begin errors++; $display("FAIL ovf_last_add: got %h expected %h", last_add, BASE + 32'hA0); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", err_o); end
        checks++; if (ntrig != 1) begin errors++; $display("FAIL ovf_trigger: got %0d expected 1", ntrig); end
    endtask

    task automatic test_mid_reset();
        int hs, t0, t1, nwr;
        bit reached;
        gnt_rand = 0; log_q.delete(); acq_q = '{32'h4};
        reached = 0;
        @(negedge clk);
        jobw_valid_i = 1'b1; jobw_data_i = 32'h50; jobw_last_i = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            #3;
            nwr = 0;
            foreach (log_q[j]) if (!log_q[j].wen) nwr++;
            if (nwr >= 2) reached = 1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL midrst_two_writes: got %0d writes expected 2", nwr); end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (periph_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b expected 0", periph_req_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
        rst_i = 1'b0;
        jobw_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        log_q.delete(); acq_q = '{32'h6};
        send_job(1, 32'h60, 0, hs, t0);
        wait_done(t1);
        checks++; if (log_q.size() < 2) begin errors++; $display("FAIL midrst_restart_count: got %0d expected >=2", log_q.size()); end
        else begin
            checks++;
            if (log_q[0].add !== BASE + 32'h04 || log_q[0].wen !== 1'b1) begin
                errors++; $display("FAIL midrst_first_acq: got add=%h wen=%b expected add=%h wen=1", log_q[0].add, log_q[0].wen, BASE + 32'h04);
            end
            checks++;
            if (log_q[1].add !== BASE + 32'h40 || log_q[1].data !== 32'h60) begin
                errors++; $display("FAIL midrst_first_word: got add=%h data=%h expected add=%h data=00000060", log_q[1].add, log_q[1].data, BASE + 32'h40);
            end
        end
        checks++; if (job_id_o !== 8'h06) begin errors++; $display("FAIL midrst_job_id: got %h expected 06", job_id_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        jobw_valid_i = 1'b0; jobw_data_i = 32'h0; jobw_last_i = 1'b0;
        evt_i = 1'b0; periph_gnt_i = 1'b0;
        periph_r_valid_i = 1'b0; periph_r_data_i = 32'h0; periph_r_id_i = 8'h0;
        test_reset();
        test_single();
        test_min_latency();
        test_retry();
        test_bad_id();
        test_stall();
        test_overflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
